sos_cascade_ctrl: RTL and testbench
===================================

// Module: sos_cascade_ctrl
// PURPOSE
//  Sequencer for a cascade of NUM_SECT biquad (filter_sos) sections forming one higher-order IIR.
//  Accepts one sample per valid/ready handshake and runs the sections in order, 0 first.
//  For each section: holds that section's input stable, pulses its trigger, waits for its done, then captures its output.
//  Sits between the ADC sample stream and the DAC/output stream; the section instances themselves sit outside this block.
// PARAMETERS
//  NUM_SECT     4    number of cascaded sections (1..8)
//  DATA_SIZE    24   sample width, two's complement
//  TIMEOUT_CYC  16   max cycles in WAIT before abort (>=3)
// PORTS
//  clk              in   1                    system clock, rising edge
//  reset            in   1                    asynchronous, active-low
//  sample_in        in   DATA_SIZE            input sample, signed
//  sample_valid     in   1                    sample_in valid
//  sample_ready     out  1                    controller idle, can accept
//  sect_bypass      in   NUM_SECT             per-section bypass mask, sampled on accept
//  sect_trig        out  NUM_SECT             one-hot 1-cycle trigger to section k (sample_trig)
//  sect_done        in   NUM_SECT             filter_done from section k
//  sect_din         out  NUM_SECT*DATA_SIZE   packed section inputs, [k*DATA_SIZE +: DATA_SIZE]
//  sect_dout        in   NUM_SECT*DATA_SIZE   packed section outputs, same packing
//  sample_out       out  DATA_SIZE            cascade result, registered
//  sample_out_valid out  1                    1-cycle pulse, sample_out is new
//  busy             out  1                    not IDLE
//  overrun          out  1                    sticky: valid sample arrived while busy
//  timeout_err      out  1                    sticky: a section missed done
//  clear_flags      in   1                    sync clear of overrun/timeout_err
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state IDLE, k=0, all din regs 0, sample_out 0.
//   - sect_trig=0, sample_out_valid=0, busy=0, overrun=0, timeout_err=0.
//   - sample_ready=1 as soon as reset is released.
//   - Reset mid-operation aborts immediately; no sample_out_valid is produced.
//  FSM: IDLE -> TRIG -> WAIT -> CAPT -> (TRIG for next k | DONE) ; DONE -> IDLE.
//  IDLE:
//   - sample_ready=1.
//   - On sample_valid: din[0]<=sample_in, bypass mask latched, k<=0 -> CHECK(k).
//  CHECK(k), folded into the transition (no extra cycle):
//   - bypass[k]=1 -> CAPT directly.
//   - bypass[k]=0 -> TRIG.
//  TRIG (1 cycle): sect_trig[k]=1; timeout counter cleared -> WAIT.
//  WAIT:
//   - Counter increments each cycle.
//   - sect_done[k]=1 -> CAPT.
//   - Counter==TIMEOUT_CYC-1 without done -> timeout_err<=1, IDLE.
//   - sect_done of any other section is ignored.
//  CAPT (1 cycle): value = bypass[k] ? din[k] : sect_dout[k] (output registers one cycle after done).
//   - k<NUM_SECT-1: din[k+1]<=value, k<=k+1, CHECK(k+1).
//   - k=NUM_SECT-1: sample_out<=value -> DONE.
//  DONE (1 cycle): sample_out_valid=1 -> IDLE.
//  din[k] holds unchanged from load until the next accepted sample; sections read data_in through their own S3.
//  Latency, all sections active: accept edge at cycle 0; TRIG0 at cycle 1; sample_out_valid at cycle 4*NUM_SECT+1.
//   - Each bypassed section subtracts 3 cycles.
//   - Minimum accept-to-accept period is 4*NUM_SECT+2 cycles.
//  sample_valid while busy: sample is dropped, overrun<=1; the current run is unaffected.
//  Flag priority: clear_flags takes priority over a same-cycle set; a flag event in the next cycle sets it again.
//  No arithmetic on samples; values pass bit-exact.
// TESTING
//  1. NUM_SECT=4, section models return din+1, done 2 cycles after trig, bypass=0, sample 100
//     -> sample_out=104, valid at cycle 17, sect_trig pulses at cycles 1,5,9,13.
//  2. bypass=4'b0101, sample 100 -> sample_out=102; only sect_trig[1] and sect_trig[3] ever pulse; valid at cycle 11.
//  3. sample_valid held high throughout -> accepts every 18 cycles; overrun=1 after first busy cycle.
//     Then clear_flags -> overrun 0 for exactly 1 cycle, then 1 again.
//  4. Section 2 never asserts done, TIMEOUT_CYC=16 -> timeout_err=1 after 16 WAIT cycles; no valid; sample_ready=1 next cycle.
//  5. reset asserted during WAIT of section 1 -> all outputs at reset values same cycle;
//     next sample 7 after release processes normally (out=11).
//  6. sample_in=24'h800000, pass-through models, bypass=0 -> sample_out=24'h800000; sign preserved.

Source files
------------

// File: rtl/sos_cascade_ctrl.sv
// Sequencer for a cascade of biquad sections: accepts one sample, steps it
// through each section in order (trigger, wait for done, capture), and emits
// the cascade result. Bypassed sections pass their input straight through.
module sos_cascade_ctrl #(
    parameter int unsigned NUM_SECT    = 4,
    parameter int unsigned DATA_SIZE   = 24,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_SIZE-1:0]          sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic [NUM_SECT-1:0]           sect_bypass,
    output logic [NUM_SECT-1:0]           sect_trig,
    input  logic [NUM_SECT-1:0]           sect_done,
    output logic [NUM_SECT*DATA_SIZE-1:0] sect_din,
    input  logic [NUM_SECT*DATA_SIZE-1:0] sect_dout,
    output logic [DATA_SIZE-1:0]          sample_out,
    output logic                          sample_out_valid,
    output logic                          busy,
    output logic                          overrun,
    output logic                          timeout_err,
    input  logic                          clear_flags
);

    localparam int unsigned K_W   = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [K_W-1:0]       k;
    logic [K_W-1:0]       k_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_SECT-1:0]  byp;
    logic [DATA_SIZE-1:0] din_q    [NUM_SECT];
    logic [DATA_SIZE-1:0] dout_arr [NUM_SECT];
    logic [DATA_SIZE-1:0] capt_val;
    logic                 last_sect;
    logic                 accept;
    logic                 timeout_ev;
    logic                 overrun_ev;
    logic [NUM_SECT-1:0]  trig_nxt;
    logic                 valid_nxt;
    logic                 busy_nxt;
    logic                 ready_nxt;

    // Pack/unpack the per-section data buses
    for (genvar g = 0; g < NUM_SECT; g++) begin : g_sect
        assign sect_din[g*DATA_SIZE +: DATA_SIZE] = din_q[g];
        assign dout_arr[g] = sect_dout[g*DATA_SIZE +: DATA_SIZE];
    end

    assign last_sect  = (k == K_W'(NUM_SECT - 1));
    assign capt_val   = byp[k] ? din_q[k] : dout_arr[k];
    assign accept     = (state == S_IDLE) && sample_valid;
    assign timeout_ev = (state == S_WAIT) && !sect_done[k] &&
                        (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign overrun_ev = sample_valid && (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and section index; a bypassed section skips straight to capture
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        case (state)
            S_IDLE: begin
                if (sample_valid) begin
                    k_nxt     = '0;
                    state_nxt = sect_bypass[0] ? S_CAPT : S_TRIG;
                end
            end
            S_TRIG: state_nxt = S_WAIT;
            S_WAIT: begin
                if (sect_done[k]) begin
                    state_nxt = S_CAPT;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_CAPT: begin
                if (last_sect) begin
                    state_nxt = S_DONE;
                end else begin
                    k_nxt     = k + K_W'(1);
                    state_nxt = byp[k_nxt] ? S_CAPT : S_TRIG;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the next state
    always_comb begin
        trig_nxt  = '0;
        valid_nxt = (state_nxt == S_DONE);
        busy_nxt  = (state_nxt != S_IDLE);
        ready_nxt = (state_nxt == S_IDLE);
        if (state_nxt == S_TRIG) begin
            trig_nxt = NUM_SECT'(1) << k_nxt;
        end
    end

    // Output registers and sticky flags; clear wins over a same-cycle set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sect_trig        <= '0;
            sample_out_valid <= 1'b0;
            busy             <= 1'b0;
            sample_ready     <= 1'b1;
            overrun          <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            sect_trig        <= trig_nxt;
            sample_out_valid <= valid_nxt;
            busy             <= busy_nxt;
            sample_ready     <= ready_nxt;
            if (clear_flags) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (overrun_ev) overrun <= 1'b1;
                if (timeout_ev) timeout_err <= 1'b1;
            end
        end
    end

    // Datapath: section index, wait counter, latched bypass mask, section inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k          <= '0;
            cnt        <= '0;
            byp        <= '0;
            sample_out <= '0;
            for (int i = 0; i < NUM_SECT; i++) begin
                din_q[i] <= '0;
            end
        end else begin
            k <= k_nxt;
            if (state == S_TRIG) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (accept) begin
                din_q[0] <= sample_in;
                byp      <= sect_bypass;
            end
            if (state == S_CAPT) begin
                if (last_sect) begin
                    sample_out <= capt_val;
                end else begin
                    din_q[k_nxt] <= capt_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_sos_cascade_ctrl.sv
// Bench for sos_cascade_ctrl: behavioural section models (done two cycles
// after trigger, output = input + inc) and a queue of expected results.
module tb_sos_cascade_ctrl;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 24;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW-1:0]     sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic [NS-1:0]     sect_bypass;
    logic [NS-1:0]     sect_trig;
    logic [NS-1:0]     sect_done;
    logic [NS*DW-1:0]  sect_din;
    logic [NS*DW-1:0]  sect_dout;
    logic [DW-1:0]     sample_out;
    logic              sample_out_valid;
    logic              busy;
    logic              overrun;
    logic              timeout_err;
    logic              clear_flags;

    logic [NS-1:0]     pend;
    logic [NS-1:0]     never_done;
    int                inc;
    logic [DW-1:0]     exp_q [$];
    int                checks = 0;
    int                errors = 0;

    sos_cascade_ctrl #(
        .NUM_SECT   (NS),
        .DATA_SIZE  (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .sect_bypass     (sect_bypass),
        .sect_trig       (sect_trig),
        .sect_done       (sect_done),
        .sect_din        (sect_din),
        .sect_dout       (sect_dout),
        .sample_out      (sample_out),
        .sample_out_valid(sample_out_valid),
        .busy            (busy),
        .overrun         (overrun),
        .timeout_err     (timeout_err),
        .clear_flags     (clear_flags)
    );

    always #5 clk = ~clk;

    // Section models: done two cycles after trigger, dout = din + inc
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      <= '0;
            sect_done <= '0;
            sect_dout <= '0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                pend[k] <= sect_trig[k];
                if (pend[k] && !never_done[k]) begin
                    sect_done[k]            <= 1'b1;
                    sect_dout[k*DW +: DW]   <= sect_din[k*DW +: DW] + DW'(inc);
                end else begin
                    sect_done[k] <= 1'b0;
                end
            end
        end
    end

    task automatic pop_check(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected sample_out_valid, got %h", name, sample_out);
        end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (sample_out !== e) begin
                errors++;
                $display("FAIL %s: sample_out got %h exp %h", name, sample_out, e);
            end
        end
    endtask

    // One sample through the cascade with per-cycle trigger/valid/busy checks
    task automatic run_one(input logic [DW-1:0] d, input logic [NS-1:0] bp, input string name);
        logic [NS-1:0] exp_trig [64];
        int c;
        int active;
        c = 1;
        active = 0;
        for (int i = 0; i < 64; i++) exp_trig[i] = '0;
        for (int k = 0; k < NS; k++) begin
            if (bp[k]) c++;
            else begin
                exp_trig[c][k] = 1'b1;
                c += 4;
                active++;
            end
        end
        checks++;
        if (sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: sample_ready before accept got %b exp 1", name, sample_ready);
        end
        sample_in    = d;
        sample_valid = 1'b1;
        sect_bypass  = bp;
        exp_q.push_back(d + DW'(inc * active));
        for (int i = 1; i <= c + 1; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                sample_valid = 1'b0;
                sect_bypass  = ~bp;
            end
            checks++;
            if (sect_trig !== exp_trig[i]) begin
                errors++;
                $display("FAIL %s: sect_trig cyc %0d got %b exp %b", name, i, sect_trig, exp_trig[i]);
            end
            checks++;
            if (sample_out_valid !== (i == c)) begin
                errors++;
                $display("FAIL %s: sample_out_valid cyc %0d got %b exp %b", name, i, sample_out_valid, (i == c));
            end
            checks++;
            if (busy !== (i <= c) || sample_ready !== (i > c)) begin
                errors++;
                $display("FAIL %s: busy/ready cyc %0d got %b/%b exp %b/%b", name, i, busy, sample_ready, (i <= c), (i > c));
            end
            if (sample_out_valid) pop_check(name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sample_in = '0; sample_valid = 1'b0; sect_bypass = '0;
        clear_flags = 1'b0; never_done = '0; inc = 1;
        #1;
        checks++;
        if (sect_trig !== '0 || sample_out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
            timeout_err !== 1'b0 || sample_out !== '0 || sect_din !== '0) begin
            errors++;
            $display("FAIL reset: trig=%b vld=%b busy=%b ovr=%b to=%b out=%h din=%h exp all 0",
                     sect_trig, sample_out_valid, busy, overrun, timeout_err, sample_out, sect_din);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sample_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b exp 1/0", sample_ready, busy);
        end
    endtask

    task automatic test_all_active();
        inc = 1;
        run_one(24'd100, 4'b0000, "all_active");
    endtask

    task automatic test_bypass();
        inc = 1;
        run_one(24'd100, 4'b0101, "bypass_0101");
        run_one(24'h00abcd, 4'b1111, "bypass_all");
        for (int n = 0; n < 4; n++) begin
            run_one(DW'($urandom), NS'($urandom_range(0, 15)), "bypass_rand");
        end
    endtask

    task automatic test_sign();
        inc = 0;
        run_one(24'h800000, 4'b0000, "sign");
        inc = 1;
    endtask

    // valid held high: accepts every 18 cycles, overrun sticky, clear wins for one cycle
    task automatic test_back_to_back();
        logic [DW-1:0] base;
        base = 24'h001000;
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        sample_in    = base;
        sample_valid = 1'b1;
        sect_bypass  = '0;
        exp_q.push_back(base + DW'(4));
        for (int i = 1; i <= 53; i++) begin
            @(posedge clk); #1;
            checks++;
            if (overrun !== (i >= 2 && i != 21)) begin
                errors++;
                $display("FAIL b2b: overrun cyc %0d got %b exp %b", i, overrun, (i >= 2 && i != 21));
            end
            checks++;
            if (sample_ready !== (i % 18 == 0) || sample_out_valid !== (i % 18 == 17)) begin
                errors++;
                $display("FAIL b2b: ready/valid cyc %0d got %b/%b exp %b/%b", i, sample_ready,
                         sample_out_valid, (i % 18 == 0), (i % 18 == 17));
            end
            if (sample_out_valid) pop_check("b2b");
            sample_in   = base + DW'(i);
            if (i % 18 == 0) exp_q.push_back(base + DW'(i) + DW'(4));
            clear_flags = (i == 20);
            if (i == 53) sample_valid = 1'b0;
        end
        @(posedge clk); #1;
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        checks++;
        if (overrun !== 1'b0 || sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_clear: overrun=%b ready=%b exp 0/1", overrun, sample_ready);
        end
    endtask

    // section 2 never completes: abort after TO wait cycles
    task automatic test_timeout();
        logic [NS-1:0] et;
        never_done   = 4'b0100;
        sample_in    = 24'd9;
        sample_valid = 1'b1;
        sect_bypass  = '0;
        for (int i = 1; i <= 28; i++) begin
            @(posedge clk); #1;
            if (i == 1) sample_valid = 1'b0;
            et = (i == 1) ? 4'b0001 : (i == 5) ? 4'b0010 : (i == 9) ? 4'b0100 : 4'b0000;
            checks++;
            if (sect_trig !== et || sample_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout: trig/valid cyc %0d got %b/%b exp %b/0", i, sect_trig, sample_out_valid, et);
            end
            checks++;
            if (timeout_err !== (i >= 26) || sample_ready !== (i >= 26)) begin
                errors++;
                $display("FAIL timeout: err/ready cyc %0d got %b/%b exp %b", i, timeout_err, sample_ready, (i >= 26));
            end
        end
        never_done = '0;
    endtask

    // async reset during section 1 wait, then a clean run
    task automatic test_reset_mid();
        sample_in    = 24'd50;
        sample_valid = 1'b1;
        sect_bypass  = '0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            sample_valid = (i == 2);
        end
        checks++;
        if (busy !== 1'b1 || overrun !== 1'b1 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: busy/ovr/to got %b/%b/%b exp 1/1/1", busy, overrun, timeout_err);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (sect_trig !== '0 || sample_out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
            timeout_err !== 1'b0 || sample_out !== '0 || sect_din !== '0 || sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: trig=%b vld=%b busy=%b ovr=%b to=%b out=%h rdy=%b exp reset values",
                     sect_trig, sample_out_valid, busy, overrun, timeout_err, sample_out, sample_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sample_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_novalid: got %b exp 0", sample_out_valid);
        end
        inc = 1;
        run_one(24'd7, 4'b0000, "after_reset");
    endtask

    initial begin
        test_reset();
        test_all_active();
        test_bypass();
        test_sign();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d results never produced, exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
